// File: rtl/seg7_capture.sv
// Seven-segment display capture: synchronises seg_in, debounces it for STABLE_CYCLES and decodes it to a hex digit.
// Optional feature: define SEG7_CAPTURE_COUNT_EN to enable the change_count update counter.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] value,
    output logic       valid,
    output logic       invalid,
    output logic       update,
    output logic [7:0] change_count
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);
    localparam logic [3:0] ACCEPT_N = 4'(STABLE_CYCLES - 1);

    logic [6:0] sync1_q, sync1_d;
    logic [6:0] sync2_q, sync2_d;
    logic [6:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       invalid_q, invalid_d;
    logic       update_q, update_d;
    logic       accept;
    logic       hit;
    logic [3:0] digit;

    // Returns {table_hit, digit} for a segment pattern (bit0 = a ... bit6 = g).
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    always_comb begin
        sync1_d = seg_in;
        sync2_d = sync1_q;
    end

    // Acceptance fires once, on the edge where the counter climbs to STABLE_N; it then saturates.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 4'd0;
        end else if (cnt_q < STABLE_N) begin
            cnt_d  = cnt_q + 4'd1;
            accept = (cnt_q == ACCEPT_N);
        end
    end

    always_comb begin
        {hit, digit} = decode_seg(cand_q);
        value_d   = value_q;
        valid_d   = valid_q;
        invalid_d = invalid_q;
        update_d  = 1'b0;
        if (accept) begin
            if (hit) begin
                value_d   = digit;
                valid_d   = 1'b1;
                invalid_d = 1'b0;
                update_d  = !valid_q || (value_q != digit);
            end else if (cand_q == 7'h00) begin
                valid_d   = 1'b0;
                invalid_d = 1'b0;
            end else begin
                valid_d   = 1'b0;
                invalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 7'h00;
            sync2_q   <= 7'h00;
            cand_q    <= 7'h00;
            cnt_q     <= 4'd0;
            value_q   <= 4'h0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
            update_q  <= update_d;
        end
    end

    assign value   = value_q;
    assign valid   = valid_q;
    assign invalid = invalid_q;
    assign update  = update_q;

`ifdef SEG7_CAPTURE_COUNT_EN
    logic [7:0] count_q, count_d;

    // Counts alongside the pulse so change_count already includes a pulse while it is high.
    always_comb begin
        count_d = count_q;
        if (update_d) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign change_count = count_q;
`else
    assign change_count = 8'h00;
`endif

endmodule
